// File: rtl/ram_image_writer_pkg.sv
// ram_image_writer_pkg
// Shared definitions for the memory image writer and its byte packer:
// FSM state encoding, bytes per memory word and the memory port widths.
package ram_image_writer_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int WORD_BYTES     = 4;

  // Byte index width inside one memory word.
  localparam int BYTE_IDX_WIDTH = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } writer_state_t;

endpackage

// File: rtl/ram_image_writer_byte_word_packer.sv
// byte_word_packer
// Assembles a little-endian memory word from a byte stream.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   clear_i           restart assembly at byte 0 with an empty buffer
//   accept_i          a byte transfers this cycle
//   byte_i            byte being transferred
//   word_next_o       buffer contents with byte_i merged at the current index
//   word_complete_o   the transfer this cycle fills the last byte of the word
module byte_word_packer
  import ram_image_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      accept_i,
  input  logic [7:0]                byte_i,
  output logic [MEM_DATA_WIDTH-1:0] word_next_o,
  output logic                      word_complete_o
);

  logic [BYTE_IDX_WIDTH-1:0] byte_idx_q;
  logic [MEM_DATA_WIDTH-1:0] buffer_q;

  // Byte k lands in bits [8k+7:8k]; the completed word is offered
  // combinationally so the writer can register it on the last handshake.
  always_comb begin
    word_next_o = buffer_q;
    word_next_o[{byte_idx_q, 3'b000} +: 8] = byte_i;
  end

  assign word_complete_o = accept_i && (byte_idx_q == BYTE_IDX_WIDTH'(WORD_BYTES - 1));

  // The index wraps naturally after the last byte, so each new word
  // starts at byte 0 without an explicit clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q <= '0;
      buffer_q   <= '0;
    end else if (clear_i) begin
      byte_idx_q <= '0;
      buffer_q   <= '0;
    end else if (accept_i) begin
      byte_idx_q <= byte_idx_q + BYTE_IDX_WIDTH'(1);
      buffer_q   <= word_next_o;
    end
  end

endmodule

// File: rtl/ram_image_writer.sv
// ram_image_writer
// Loads a byte stream into RAM as little-endian 32-bit words at
// base, base+4, base+8, ... (the layout the boot ROM serves).
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   start          command strobe, honoured only while idle
//   base_addr      first byte address (low two bits ignored)
//   word_count     number of words to write (0 completes immediately)
//   in_byte/in_valid/in_ready   byte stream handshake
//   mem_address/mem_data/mem_write   one-cycle RAM write port
//   busy           command in progress
//   done           one-cycle completion pulse
//   wrap_error     sticky: the address ran past the top of memory
module ram_image_writer
  import ram_image_writer_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [COUNT_WIDTH-1:0]    word_count,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic [MEM_DATA_WIDTH-1:0] mem_data,
  output logic                      mem_write,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap_error
);

  localparam logic [ADDR_WIDTH-1:0] TOP_WORD_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  writer_state_t             state_q;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic                      in_ready_q, mem_write_q, busy_q, done_q, wrap_error_q;
  logic [ADDR_WIDTH-1:0]     mem_address_q;
  logic [MEM_DATA_WIDTH-1:0] mem_data_q;

  logic                      accept, start_accepted, word_complete;
  logic [MEM_DATA_WIDTH-1:0] word_next;
  logic                      unused_base_bits;

  // Base address is forced word-aligned, so its low bits never matter.
  assign unused_base_bits = ^base_addr[1:0];

  assign accept         = (state_q == COLLECT) && in_valid && in_ready_q;
  assign start_accepted = (state_q == IDLE) && start;
  assign addr_d         = addr_q + ADDR_WIDTH'(WORD_BYTES);
  assign remaining_d    = remaining_q - COUNT_WIDTH'(1);

  byte_word_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (start_accepted),
    .accept_i        (accept),
    .byte_i          (in_byte),
    .word_next_o     (word_next),
    .word_complete_o (word_complete)
  );

  // Command FSM. Outputs are registered alongside the state so each one
  // reflects the state being entered; mem_write and done default low so
  // they can only ever last a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      in_ready_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wrap_error_q  <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q       <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            remaining_q  <= word_count;
            wrap_error_q <= 1'b0;
            busy_q       <= 1'b1;
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= COLLECT;
              in_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (word_complete) begin
            state_q       <= WRITE;
            in_ready_q    <= 1'b0;
            mem_write_q   <= 1'b1;
            mem_address_q <= addr_q;
            mem_data_q    <= word_next;
          end
        end
        WRITE: begin
          addr_q      <= addr_d;
          remaining_q <= remaining_d;
          // Only flag a wrap when another word will really use the wrapped address.
          if ((addr_q == TOP_WORD_ADDR) && (remaining_q > COUNT_WIDTH'(1))) begin
            wrap_error_q <= 1'b1;
          end
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrap_error  = wrap_error_q;

endmodule

// File: tb/tb_ram_image_writer.sv
// tb_ram_image_writer
// Drives commands and byte streams into ram_image_writer and compares every
// RAM write, completion pulse and status flag against a word-list model.
module tb_ram_image_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic        wrap_error;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        expQ[$];
  int         expCycQ[$];
  logic [7:0] byteQ[$];
  int         validPat[$];
  wr_t        monE;
  logic       expWrap;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int writesSeen = 0;
  int donesSeen  = 0;
  int doneCyc    = 0;
  int lastWriteCyc = 0;
  int startCyc   = 0;

  ram_image_writer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_write   (mem_write),
    .busy        (busy),
    .done        (done),
    .wrap_error  (wrap_error)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Watches the write port and done pulse on the falling edge and retires
  // expected writes in order.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_write) begin
        writesSeen++;
        lastWriteCyc = cyc;
        checkOutput("ready_in_write", {31'd0, in_ready}, 32'd0);
        checkOutput("busy_in_write", {31'd0, busy}, 32'd1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", {31'd0, mem_write}, 32'd0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("wr_addr", {16'd0, mem_address}, {16'd0, monE.addr});
          checkOutput("wr_data", mem_data, monE.data);
        end
        if (expCycQ.size() > 0) checkOutput("wr_latency", cyc, expCycQ.pop_front());
      end
      if (done) begin
        donesSeen++;
        doneCyc = cyc;
        checkOutput("ready_in_done", {31'd0, in_ready}, 32'd0);
        checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Asynchronous reset with a check of every output while it is held.
  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_address", {16'd0, mem_address}, 32'd0);
    checkOutput("rst_mem_data", mem_data, 32'd0);
    checkOutput("rst_wrap_error", {31'd0, wrap_error}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic fillRandomBytes(input int n);
    byteQ.delete();
    for (int i = 0; i < n; i++) byteQ.push_back(8'($urandom));
  endtask

  // Issues a command; when withModel is set, the expected word list and
  // wrap outcome are derived from base, count and the queued bytes.
  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] cnt, input bit withModel);
    int c = int'(cnt);
    logic [15:0] a;
    expQ.delete();
    expCycQ.delete();
    expWrap = 1'b0;
    if (withModel) begin
      for (int i = 0; i < c; i++) begin
        wr_t e;
        a = {base[15:2], 2'b00} + 16'(4 * i);
        e.addr = a;
        e.data = {byteQ[4*i+3], byteQ[4*i+2], byteQ[4*i+1], byteQ[4*i]};
        expQ.push_back(e);
        if (a == 16'hFFFC && i < c - 1) expWrap = 1'b1;
      end
    end
    writesSeen = 0;
    donesSeen  = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(posedge clk); #1;
    start    = 1'b0;
    startCyc = cyc;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("wrap_clr", {31'd0, wrap_error}, 32'd0);
  endtask

  // Offers n bytes with either a fixed valid pattern or a random duty
  // cycle; a byte counts as sent only when valid meets ready at an edge.
  task automatic feedBytes(input int n, input int validPct, input bit strayStart);
    int idx = 0;
    int it = 0;
    int budget = 400;
    bit rdy;
    while (idx < n && budget > 0) begin
      if (validPat.size() > 0) in_valid = (validPat[it % validPat.size()] != 0);
      else in_valid = ($urandom_range(99) < validPct);
      in_byte = in_valid ? byteQ[idx] : 8'($urandom);
      start = strayStart && (it == 1);
      if (start) begin
        base_addr  = 16'($urandom);
        word_count = 16'($urandom);
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        idx++;
        if (idx % 4 == 0) expCycQ.push_back(cyc);
      end
      it++;
      budget--;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("feed_progress", idx, n);
  endtask

  // Waits (bounded) for completion and checks the command outcome.
  task automatic waitDone(input int cnt);
    int budget = 60;
    while (donesSeen == 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    checkOutput("done_seen", donesSeen, 1);
    checkOutput("write_count", writesSeen, cnt);
    checkOutput("writes_left", expQ.size(), 0);
    if (cnt == 0) checkOutput("done_lat0", doneCyc, startCyc);
    else checkOutput("done_lat", doneCyc, lastWriteCyc + 1);
    checkOutput("wrap_flag", {31'd0, wrap_error}, {31'd0, expWrap});
    @(posedge clk); #1;
    checkOutput("busy_after", {31'd0, busy}, 32'd0);
    checkOutput("done_pulse_len", {31'd0, done}, 32'd0);
    validPat.delete();
  endtask

  // Junk on the stream while idle must never be taken.
  task automatic idleJunk(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      @(negedge clk);
      checkOutput("ready_idle", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_byte    = '0;
    in_valid   = 1'b0;
    doReset();

    // Abort a partially collected word with reset, then load ROM word 0x40.
    byteQ = '{8'h11, 8'h22};
    validPat = '{1};
    applyStimulus(16'h0040, 16'd1, 1'b0);
    feedBytes(2, 100, 1'b0);
    doReset();
    checkOutput("no_done_after_abort", donesSeen, 0);
    checkOutput("no_write_after_abort", writesSeen, 0);
    byteQ = '{8'h44, 8'h00, 8'h00, 8'h00};
    applyStimulus(16'h0040, 16'd1, 1'b1);
    feedBytes(4, 100, 1'b0);
    waitDone(1);

    // Back-to-back words with valid held high.
    byteQ = '{8'h82, 8'hBF, 8'h78, 8'h57, 8'hFA, 8'hFF, 8'h41, 8'hFE};
    validPat = '{1};
    applyStimulus(16'h0000, 16'd2, 1'b1);
    feedBytes(8, 100, 1'b0);
    waitDone(2);

    // Stalling valid pattern.
    fillRandomBytes(4);
    validPat = '{1, 0, 0, 1, 1, 0, 1};
    applyStimulus(16'h0123, 16'd1, 1'b1);
    feedBytes(4, 100, 1'b0);
    waitDone(1);

    // Zero-length command.
    idleJunk(2);
    applyStimulus(16'h0200, 16'd0, 1'b1);
    waitDone(0);

    // Address wrap past the top of memory, then a command that clears it.
    fillRandomBytes(8);
    applyStimulus(16'hFFFE, 16'd2, 1'b1);
    feedBytes(8, 70, 1'b0);
    waitDone(2);
    fillRandomBytes(4);
    applyStimulus(16'h0100, 16'd1, 1'b1);
    feedBytes(4, 100, 1'b0);
    waitDone(1);

    // Start pulsed mid-command is ignored.
    fillRandomBytes(8);
    applyStimulus(16'h0310, 16'd2, 1'b1);
    feedBytes(8, 80, 1'b1);
    waitDone(2);

    // Randomized commands.
    for (int r = 0; r < 25; r++) begin
      logic [15:0] b;
      int n;
      b = 16'($urandom);
      if ($urandom_range(3) == 0) b = 16'hFFF0 | 16'($urandom_range(15));
      n = $urandom_range(3);
      fillRandomBytes(4 * n);
      idleJunk($urandom_range(3));
      applyStimulus(b, 16'(n), 1'b1);
      if (n > 0) feedBytes(4 * n, $urandom_range(40, 100), $urandom_range(1) == 1);
      waitDone(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_image_writer.md
Name: ram_image_writer

Overview:
- Writer-side counterpart of the 32-bit, 16-bit-address memory read path (ROM_BOOT / program memory).
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes each word into RAM at byte addresses base, base+4, base+8, ...
- Used by the emulator to load program images (the same layout ROM_BOOT serves) into writable memory.

Parameters:
- ADDR_WIDTH, 16, byte-address width of the memory port.
- COUNT_WIDTH, 16, width of the word-count command field.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first byte address; bits [1:0] are ignored and treated as 0.
- word_count  input  COUNT_WIDTH  number of 32-bit words to write.
- in_byte  input  8  stream data.
- in_valid  input  1  stream data valid.
- in_ready  output  1  writer can accept a byte.
- mem_address  output  ADDR_WIDTH  RAM byte address (word-aligned).
- mem_data  output  32  RAM write data.
- mem_write  output  1  single-cycle write strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the command completes.
- wrap_error  output  1  sticky flag: address wrapped past the top of the address space.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including mem_address and mem_data.
  - Byte index, word buffer, address register and remaining count are cleared.
  - A partially assembled word is discarded.
  - Reset asserted mid-command aborts the command with no done pulse.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start=1:
    - Latch addr={base_addr[ADDR_WIDTH-1:2],2'b00} and remaining=word_count.
    - Clear wrap_error and byte index.
    - If word_count==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - in_ready=1.
  - A byte transfers only in a cycle with in_valid && in_ready.
  - Byte k (k=0..3) goes to buffer bits [8k+7:8k].
  - When the transfer with k==3 occurs, go to WRITE; in_ready is 0 on the following cycle.
  - If in_valid stays low, the block waits indefinitely.
- WRITE (exactly one cycle):
  - mem_write=1, mem_address=addr, mem_data=buffer, in_ready=0.
  - Next edge: addr<=addr+4 (modulo 2^ADDR_WIDTH) and remaining<=remaining-1.
  - If addr was 2^ADDR_WIDTH-4 and remaining>1, set wrap_error=1.
  - If remaining==1, go to DONE; otherwise go to COLLECT with byte index 0.
- DONE:
  - done=1 for one cycle, busy=1.
  - Next state is IDLE.
- Latency and throughput:
  - mem_write rises on the cycle after the 4th byte handshake.
  - Peak rate is 1 word per 5 cycles.
- Output hold: mem_address and mem_data hold their last written value while mem_write=0. They are meaningful only when mem_write=1.
- start asserted outside IDLE is ignored; no queuing.
- in_valid/in_byte outside COLLECT are ignored; no byte is consumed.
- wrap_error stays set until the next accepted start or reset. Writing continues after a wrap (wrapped addresses are written).
- A count of 2^COUNT_WIDTH-1 words is supported; remaining never underflows.

Decomposition:
- Shared package / include file (used by the memory blocks):
  - State encoding constants: IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2, DONE=2'd3.
  - WORD_BYTES=4.
  - Memory address width 16 and data width 32.
- One natural sub-module: byte_word_packer, containing:
  - the byte index counter;
  - the little-endian 32-bit buffer;
  - a word_complete output.
- The FSM and address/count registers stay in ram_image_writer.

Test Plan:
1. Reset during COLLECT after 2 bytes, then start base=0x0040 count=1 with bytes 44,00,00,00:
   - Single write: address 0x0040, data 0x00000044.
   - Partial word from before reset is not written; then done pulse.
   - Loading this into RAM reproduces ROM_BOOT word 0x40.
2. start base=0x0000 count=2 with bytes 82,BF,78,57,FA,FF,41,FE, in_valid held high:
   - Writes (0x0000, 0x5778BF82) then (0x0004, 0xFE41FFFA).
   - mem_write high exactly 2 cycles, each 1 cycle after the 4th byte.
   - done 1 cycle after the 2nd write; busy low afterwards.
3. Stall: in_valid toggles 1-0-0-1-1-0-1:
   - Only 4 bytes consumed; one write with the correct word.
   - in_ready=0 during WRITE and DONE.
4. start with word_count=0:
   - IDLE -> DONE -> IDLE; done pulses one cycle after start.
   - No mem_write, no in_ready.
5. base=0xFFFE count=2:
   - Writes at 0xFFFC then 0x0000; wrap_error=1 after the first write.
   - Next start clears wrap_error.
6. start pulsed during COLLECT:
   - Ignored; address, count and data unchanged; exactly the original number of writes occurs.
